// File: rtl/hps_instr_pkg.sv
// hps_instr_pkg: shared definitions for the HPS instruction endpoint.
//   - 64-bit instruction field positions: [63:32] data, [31:16] opcode, [15:0] address
//   - OP_WRITE opcode and default base addresses for the control and readback banks
//   - Readback handshake FSM state encoding
//   - make_rsp: builds a readback word (opcode field is always zero)
package hps_instr_pkg;

  localparam int DATA_MSB = 63;
  localparam int DATA_LSB = 32;
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  localparam logic [15:0] OP_WRITE = 16'd0;

  localparam int DEF_WR_BASE = 100;
  localparam int DEF_RD_BASE = 300;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_LOW
  } rd_state_e;

  function automatic logic [63:0] make_rsp(input logic [31:0] data, input logic [15:0] addr);
    return {data, 16'd0, addr};
  endfunction

endpackage

// File: rtl/hps_instr_fifo.sv
// hps_instr_fifo: synchronous show-ahead FIFO.
//   i_clk / i_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write side; a push while full is ignored
//   i_pop           : read side; o_data always shows the head, a pop while empty is ignored
//   o_full, o_empty : decoded from the registered occupancy count
//   o_count         : number of stored entries (0..DEPTH)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module hps_instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hps_instr_endpoint.sv
// hps_instr_endpoint: fabric-side responder for the HPS instruction link.
//   s_clk, s_reset  : sole clock, synchronous active-high reset
//   wr, wr_busy     : write-instruction strobe; busy while the command FIFO is full
//   wr_instruction  : [63:32] data, [31:16] opcode, [15:0] address
//   rd, rd_valid    : readback handshake (present, ack high, ack low again)
//   rd_instruction  : [63:32] data, [31:16] zero, [15:0] readback address
//   ctrl_q          : control register bank, word i at [32i+31:32i]
//   stat_in         : status words from user logic, published when they change
//   err_cnt/ovf_cnt : saturating counts of discarded / dropped instructions
// Valid control writes are echoed at RD_BASE+i; status word k is reported at
// RD_BASE+NUM_CTRL+k.
module hps_instr_endpoint
  import hps_instr_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 8,
  parameter int NUM_CTRL  = 8,
  parameter int NUM_STAT  = 8,
  parameter int WR_BASE   = DEF_WR_BASE,
  parameter int RD_BASE   = DEF_RD_BASE
) (
  input  logic                     s_clk,
  input  logic                     s_reset,
  input  logic                     wr,
  output logic                     wr_busy,
  input  logic [63:0]              wr_instruction,
  input  logic                     rd,
  output logic                     rd_valid,
  output logic [63:0]              rd_instruction,
  output logic [32*NUM_CTRL-1:0]   ctrl_q,
  input  logic [32*NUM_STAT-1:0]   stat_in,
  output logic [15:0]              err_cnt,
  output logic [15:0]              ovf_cnt
);

  localparam int CIW = $clog2(CMD_DEPTH) + 1;
  localparam int RIW = $clog2(RSP_DEPTH) + 1;
  localparam int CW  = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int SW  = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

  // ---------------------------------------------------------------- command FIFO
  logic [63:0]    w_cmd_head;
  logic           w_cmd_full;
  logic           w_cmd_empty;
  logic [CIW-1:0] w_cmd_count;
  logic           w_cmd_push;
  logic           w_exec;

  assign w_cmd_push = wr && !w_cmd_full;
  assign wr_busy    = (w_cmd_count == CIW'(CMD_DEPTH));

  hps_instr_fifo #(.WIDTH(64), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (s_clk),
    .i_reset (s_reset),
    .i_push  (w_cmd_push),
    .i_data  (wr_instruction),
    .i_pop   (w_exec),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  // ---------------------------------------------------------------- response FIFO
  logic [63:0]    w_rsp_head;
  logic [63:0]    w_rsp_din;
  logic           w_rsp_full;
  logic           w_rsp_empty;
  logic           w_rsp_push;
  logic           w_rsp_pop;
  logic [RIW-1:0] w_rsp_count_unused;

  hps_instr_fifo #(.WIDTH(64), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_clk   (s_clk),
    .i_reset (s_reset),
    .i_push  (w_rsp_push),
    .i_data  (w_rsp_din),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count_unused)
  );

  // ---------------------------------------------------------------- execute / decode
  logic [15:0]   w_op;
  logic [15:0]   w_addr;
  logic [31:0]   w_data;
  logic [15:0]   w_off;
  logic          w_cmd_ok;
  logic          w_echo_push;
  logic          w_err_inc;
  logic [CW-1:0] w_ctrl_idx;
  logic [15:0]   w_echo_addr;

  // Any head (good or bad) waits while the response FIFO is full, so a
  // discard never overtakes a write that is still waiting for echo space.
  assign w_exec      = !w_cmd_empty && !w_rsp_full;
  assign w_op        = w_cmd_head[OP_MSB:OP_LSB];
  assign w_addr      = w_cmd_head[ADDR_MSB:ADDR_LSB];
  assign w_data      = w_cmd_head[DATA_MSB:DATA_LSB];
  assign w_off       = w_addr - 16'(WR_BASE);
  assign w_cmd_ok    = (w_op == OP_WRITE) && (w_addr >= 16'(WR_BASE)) &&
                       (w_off < 16'(NUM_CTRL));
  assign w_echo_push = w_exec && w_cmd_ok;
  assign w_err_inc   = w_exec && !w_cmd_ok;
  assign w_ctrl_idx  = w_off[CW-1:0];
  assign w_echo_addr = 16'(RD_BASE) + w_off;

  logic [31:0] r_ctrl [NUM_CTRL];

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        r_ctrl[i] <= '0;
      end
    end else if (w_echo_push) begin
      r_ctrl[w_ctrl_idx] <= w_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
      assign ctrl_q[32*gi +: 32] = r_ctrl[gi];
    end
  endgenerate

  // ---------------------------------------------------------------- status scanner
  logic [31:0]         w_stat [NUM_STAT];
  logic [31:0]         r_shadow [NUM_STAT];
  logic [NUM_STAT-1:0] r_dirty;
  logic [SW-1:0]       r_scan_idx;
  logic [31:0]         w_stat_cur;
  logic                w_stat_diff;
  logic                w_scan_push;
  logic                w_scan_adv;
  logic [15:0]         w_stat_addr;

  generate
    for (gi = 0; gi < NUM_STAT; gi++) begin : g_stat_in
      assign w_stat[gi] = stat_in[32*gi +: 32];
    end
  endgenerate

  assign w_stat_cur  = w_stat[r_scan_idx];
  assign w_stat_diff = r_dirty[r_scan_idx] || (w_stat_cur != r_shadow[r_scan_idx]);
  // Echoes own the single push slot; a pending status word just holds its index.
  assign w_scan_push = w_stat_diff && !w_echo_push && !w_rsp_full;
  assign w_scan_adv  = !w_stat_diff || w_scan_push;
  assign w_stat_addr = 16'(RD_BASE + NUM_CTRL) + 16'(r_scan_idx);

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      r_scan_idx <= '0;
      r_dirty    <= '1;
      for (int i = 0; i < NUM_STAT; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      if (w_scan_push) begin
        r_shadow[r_scan_idx] <= w_stat_cur;
        r_dirty[r_scan_idx]  <= 1'b0;
      end
      if (w_scan_adv) begin
        r_scan_idx <= (r_scan_idx == SW'(NUM_STAT - 1)) ? '0 : r_scan_idx + 1'b1;
      end
    end
  end

  assign w_rsp_push = w_echo_push || w_scan_push;
  assign w_rsp_din  = w_echo_push ? make_rsp(w_data, w_echo_addr)
                                  : make_rsp(w_stat_cur, w_stat_addr);

  // ---------------------------------------------------------------- counters
  logic [15:0] r_err_cnt;
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      r_err_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (wr && w_cmd_full && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  assign err_cnt = r_err_cnt;
  assign ovf_cnt = r_ovf_cnt;

  // ---------------------------------------------------------------- readback FSM
  rd_state_e   r_rd_state;
  logic        r_rd_valid;
  logic [63:0] r_rd_instruction;

  // The word is popped on the first acknowledged cycle; WAIT_LOW then
  // swallows the rest of a long rd pulse.
  assign w_rsp_pop = (r_rd_state == PRESENT) && rd;

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      r_rd_state       <= IDLE;
      r_rd_valid       <= 1'b0;
      r_rd_instruction <= '0;
    end else begin
      case (r_rd_state)
        IDLE: begin
          if (!w_rsp_empty && !rd) begin
            r_rd_instruction <= w_rsp_head;
            r_rd_valid       <= 1'b1;
            r_rd_state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (rd) begin
            r_rd_valid <= 1'b0;
            r_rd_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!rd) begin
            r_rd_state <= IDLE;
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_rd_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_valid       = r_rd_valid;
  assign rd_instruction = r_rd_instruction;

endmodule

// File: tb/tb_hps_instr_endpoint.sv
// tb_hps_instr_endpoint: directed, table-driven bench for hps_instr_endpoint.
// Expected words are hand-computed from the instruction format and the
// readback address map (ctrl echo at 300+i, status at 308+k).
module tb_hps_instr_endpoint;

  logic         s_clk;
  logic         s_reset;
  logic         wr;
  logic         wr_busy;
  logic [63:0]  wr_instruction;
  logic         rd;
  logic         rd_valid;
  logic [63:0]  rd_instruction;
  logic [255:0] ctrl_q;
  logic [255:0] stat_in;
  logic [15:0]  err_cnt;
  logic [15:0]  ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hps_instr_endpoint dut (
    .s_clk          (s_clk),
    .s_reset        (s_reset),
    .wr             (wr),
    .wr_busy        (wr_busy),
    .wr_instruction (wr_instruction),
    .rd             (rd),
    .rd_valid       (rd_valid),
    .rd_instruction (rd_instruction),
    .ctrl_q         (ctrl_q),
    .stat_in        (stat_in),
    .err_cnt        (err_cnt),
    .ovf_cnt        (ovf_cnt)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [63:0] instr;
    int          idx;
    logic [31:0] exp_ctrl;
    logic [15:0] exp_err;
    logic        has_rsp;
    logic [63:0] exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a presented word, compare it, then ack with a 2-cycle rd pulse.
  task automatic read_word(input string name, input logic [63:0] exp);
    int t = 0;
    while (!rd_valid && t < 60) begin
      tick();
      t++;
    end
    chk({name, "_valid"}, 64'(rd_valid), 64'd1);
    chk(name, rd_instruction, exp);
    $display("rd %s: %h", name, rd_instruction);
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
  endtask

  function automatic logic [63:0] rsp(input logic [31:0] d, input int a);
    return {d, 16'd0, 16'(a)};
  endfunction

  initial begin
    s_reset        = 1'b1;
    wr             = 1'b0;
    rd             = 1'b0;
    wr_instruction = '0;
    for (int k = 0; k < 8; k++) stat_in[32*k +: 32] = 32'h1000 + 32'(k);

    // ---- test 1: reset state and initial status publication
    tick();
    tick();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_instr", rd_instruction, 64'd0);
    chk("rst_wr_busy", 64'(wr_busy), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("rst_ctrl", ctrl_q[63:0], 64'd0);
    s_reset = 1'b0;
    for (int k = 0; k < 8; k++)
      read_word($sformatf("stat%0d", k), rsp(32'h1000 + 32'(k), 308 + k));
    repeat (20) tick();
    chk("stat_quiet", 64'(rd_valid), 64'd0);

    // ---- tests 2 and 5: table of single instructions with exact latency
    vecs[0] = '{64'hDEADBEEF_0000_0066, 2, 32'hDEADBEEF, 16'd0, 1'b1, 64'hDEADBEEF_0000_012E};
    vecs[1] = '{64'h12345678_0000_0064, 0, 32'h12345678, 16'd0, 1'b1, 64'h12345678_0000_012C};
    vecs[2] = '{64'hCAFEF00D_0000_006B, 7, 32'hCAFEF00D, 16'd0, 1'b1, 64'hCAFEF00D_0000_0133};
    vecs[3] = '{64'h00000001_0000_0032, 1, 32'h0,        16'd1, 1'b0, 64'h0};
    vecs[4] = '{64'h00000002_0001_0065, 1, 32'h0,        16'd2, 1'b0, 64'h0};
    vecs[5] = '{64'h00000003_0000_006C, 1, 32'h0,        16'd3, 1'b0, 64'h0};
    vecs[6] = '{64'h00000004_0000_0063, 1, 32'h0,        16'd4, 1'b0, 64'h0};
    for (int v = 0; v < 7; v++) begin
      wr_instruction = vecs[v].instr;
      wr = 1'b1;
      tick();                       // E0: command captured
      wr = 1'b0;
      tick();                       // E1: executed
      chk($sformatf("v%0d_ctrl", v), 64'(ctrl_q[32*vecs[v].idx +: 32]), 64'(vecs[v].exp_ctrl));
      chk($sformatf("v%0d_err", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      tick();                       // E2: word presented if echoed
      chk($sformatf("v%0d_rdv", v), 64'(rd_valid), 64'(vecs[v].has_rsp));
      if (vecs[v].has_rsp) read_word($sformatf("v%0d_echo", v), vecs[v].exp_rsp);
    end
    repeat (5) tick();
    chk("bad_no_rsp", 64'(rd_valid), 64'd0);

    // ---- test 3: a single status change is reported once
    stat_in[32*3 +: 32] = 32'h55;
    read_word("stat3_chg", 64'h00000055_0000_0137);
    repeat (20) tick();
    chk("stat3_once", 64'(rd_valid), 64'd0);

    // ---- test 4: fill response FIFO, then command FIFO, then overflow
    for (int i = 0; i < 13; i++) begin
      if (i < 8)       wr_instruction = {32'hA000_0000 + 32'(i), 16'd0, 16'(100 + i)};
      else if (i < 12) wr_instruction = {32'hB000_0000 + 32'(i), 16'd0, 16'(100 + i - 8)};
      else             wr_instruction = 64'hC0DEC0DE_0000_0064;
      if (i == 12) chk("busy_full", 64'(wr_busy), 64'd1);
      wr = 1'b1;
      tick();
    end
    wr = 1'b0;
    chk("ovf_one", 64'(ovf_cnt), 64'd1);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) read_word($sformatf("fill%0d", i), rsp(32'hA000_0000 + 32'(i), 300 + i));
      else       read_word($sformatf("fill%0d", i), rsp(32'hB000_0000 + 32'(i), 300 + i - 8));
    end
    repeat (20) tick();
    chk("fill_drained", 64'(rd_valid), 64'd0);
    chk("fill_busy", 64'(wr_busy), 64'd0);
    chk("fill_err", 64'(err_cnt), 64'd4);
    for (int i = 0; i < 8; i++)
      chk($sformatf("fill_ctrl%0d", i), 64'(ctrl_q[32*i +: 32]),
          (i < 4) ? 64'(32'hB000_0008 + 32'(i)) : 64'(32'hA000_0000 + 32'(i)));

    // ---- test 6: long rd pops one word; reset while presenting
    wr_instruction = 64'h60000001_0000_0068;
    wr = 1'b1;
    tick();
    wr_instruction = 64'h60000002_0000_0069;
    tick();
    wr = 1'b0;
    for (int t = 0; t < 60 && !rd_valid; t++) tick();
    chk("long_first", rd_instruction, 64'h60000001_0000_0130);
    rd = 1'b1;
    repeat (5) tick();
    chk("long_held", 64'(rd_valid), 64'd0);
    rd = 1'b0;
    tick();
    chk("long_gap", 64'(rd_valid), 64'd0);
    tick();
    chk("long_next_v", 64'(rd_valid), 64'd1);
    chk("long_next", rd_instruction, 64'h60000002_0000_0131);
    s_reset = 1'b1;
    tick();
    chk("mid_rst_rdv", 64'(rd_valid), 64'd0);
    chk("mid_rst_instr", rd_instruction, 64'd0);
    chk("mid_rst_ctrl", 64'(ctrl_q[32*4 +: 32]), 64'd0);
    chk("mid_rst_err", 64'(err_cnt), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
    s_reset = 1'b0;
    for (int k = 0; k < 8; k++)
      read_word($sformatf("repub%0d", k),
                rsp((k == 3) ? 32'h55 : 32'h1000 + 32'(k), 308 + k));
    repeat (20) tick();
    chk("repub_quiet", 64'(rd_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
